// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU opcodes, control bit positions, flags.
// Imported by alu64 and ex_stage.
package ex_pkg;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_XOR  = 3'b110
    } alu_op_e;

    localparam int unsigned CTL_ALU_HI   = 9;
    localparam int unsigned CTL_ALU_LO   = 7;
    localparam int unsigned CTL_ALUSRC   = 6;
    localparam int unsigned CTL_ADDI     = 5;
    localparam int unsigned CTL_SETFLAG  = 4;
    localparam int unsigned CTL_MEMWRITE = 3;
    localparam int unsigned CTL_MEMTOREG = 2;
    localparam int unsigned CTL_LSR      = 1;
    localparam int unsigned CTL_REGWRITE = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu64.sv
// Combinational 64-bit ALU with logical shift right and NZCV generation.
// LSR overrides the ALU opcode.
module alu64
    import ex_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  alu_op_e     op,
    input  logic        lsr,
    input  logic [5:0]  shamt,
    output logic [63:0] result,
    output flags_t      flags
);

    logic [64:0] sum;
    logic [64:0] dif;

    assign sum = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so bit 64 is the not-borrow carry.
    assign dif = {1'b0, a} + {1'b0, ~b} + 65'd1;

    always_comb begin
        result = b;
        flags  = '0;
        if (lsr) begin
            result = a >> shamt;
        end else begin
            case (op)
                ALU_ADD: begin
                    result  = sum[63:0];
                    flags.c = sum[64];
                    flags.v = (a[63] == b[63]) && (sum[63] != a[63]);
                end
                ALU_SUB: begin
                    result  = dif[63:0];
                    flags.c = dif[64];
                    flags.v = (a[63] != b[63]) && (dif[63] != a[63]);
                end
                ALU_AND: result = a & b;
                ALU_OR:  result = a | b;
                ALU_XOR: result = a ^ b;
                default: result = b;
            endcase
        end
        flags.n = result[63];
        flags.z = (result == 64'd0);
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand-B select, ALU/shift, EX/MEM slot and NZCV register.
// Flush outranks stall; flags only move on a live, unstalled, unflushed SetFlag.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Da_in,
    input  logic [DATA_W-1:0] Db_in,
    input  logic [9:0]        control_in,
    input  logic [4:0]        Rd_in,
    input  logic [8:0]        Imm9_in,
    input  logic [11:0]       Imm12_in,
    input  logic [5:0]        shamt_in,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] Db_out,
    output logic [4:0]        Rd_out,
    output logic [2:0]        mem_ctrl_out,
    output logic              valid_out,
    output logic [3:0]        flags_out
);

    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_res;
    flags_t            alu_flags;
    flags_t            flag_q;
    logic [2:0]        mem_ctrl;

    always_comb begin
        opb = Db_in;
        if (control_in[CTL_ALUSRC]) begin
            if (control_in[CTL_ADDI])
                opb = {{(DATA_W-12){1'b0}}, Imm12_in};
            else
                opb = {{(DATA_W-9){Imm9_in[8]}}, Imm9_in};
        end
    end

    alu64 u_alu (
        .a      (Da_in),
        .b      (opb),
        .op     (alu_op_e'(control_in[CTL_ALU_HI:CTL_ALU_LO])),
        .lsr    (control_in[CTL_LSR]),
        .shamt  (shamt_in),
        .result (alu_res),
        .flags  (alu_flags)
    );

    assign mem_ctrl = {control_in[CTL_MEMWRITE],
                       control_in[CTL_MEMTOREG],
                       control_in[CTL_REGWRITE]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_out   <= '0;
            Db_out       <= '0;
            Rd_out       <= '0;
            mem_ctrl_out <= '0;
            valid_out    <= 1'b0;
            flag_q       <= '0;
        end else if (flush) begin
            result_out   <= alu_res;
            Db_out       <= Db_in;
            Rd_out       <= Rd_in;
            mem_ctrl_out <= '0;
            valid_out    <= 1'b0;
        end else if (!stall) begin
            result_out   <= alu_res;
            Db_out       <= Db_in;
            Rd_out       <= Rd_in;
            mem_ctrl_out <= valid_in ? mem_ctrl : 3'b000;
            valid_out    <= valid_in;
            if (valid_in && control_in[CTL_SETFLAG])
                flag_q <= alu_flags;
        end
    end

    assign flags_out = flag_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed table, stall/flush/reset sequences and
// randomized traffic against a behavioural model.
module tb_ex_stage;

    typedef struct {
        logic [9:0]  ctrl;
        logic [63:0] da;
        logic [63:0] db;
        logic [4:0]  rd;
        logic [8:0]  imm9;
        logic [11:0] imm12;
        logic [5:0]  shamt;
        logic        valid;
        logic        stall;
        logic        flush;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [63:0] eres;
        logic [2:0]  emc;
        logic [3:0]  efl;
    } row_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Da_in, Db_in;
    logic [9:0]  control_in;
    logic [4:0]  Rd_in;
    logic [8:0]  Imm9_in;
    logic [11:0] Imm12_in;
    logic [5:0]  shamt_in;
    logic        valid_in, stall, flush;
    logic [63:0] result_out, Db_out;
    logic [4:0]  Rd_out;
    logic [2:0]  mem_ctrl_out;
    logic        valid_out;
    logic [3:0]  flags_out;

    int n_pass = 0;
    int n_total = 0;

    logic [63:0] e_res, e_db;
    logic [4:0]  e_rd;
    logic [2:0]  e_mc;
    logic        e_v;
    logic [3:0]  e_fl;

    row_t tbl[10];

    ex_stage #(.DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .Da_in(Da_in), .Db_in(Db_in), .control_in(control_in),
        .Rd_in(Rd_in), .Imm9_in(Imm9_in), .Imm12_in(Imm12_in),
        .shamt_in(shamt_in), .valid_in(valid_in), .stall(stall),
        .flush(flush), .result_out(result_out), .Db_out(Db_out),
        .Rd_out(Rd_out), .mem_ctrl_out(mem_ctrl_out),
        .valid_out(valid_out), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: operand select, op semantics and flags straight from the rules.
    function automatic void model(input vec_t v, output logic [63:0] r,
                                  output logic [3:0] f);
        logic [63:0] a, b;
        longint sa, sb, sr;
        logic c, ov;
        a = v.da;
        if (!v.ctrl[6]) b = v.db;
        else if (v.ctrl[5]) b = {52'd0, v.imm12};
        else b = 64'($signed(v.imm9));
        c = 1'b0;
        ov = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        if (v.ctrl[1]) r = a >> v.shamt;
        else begin
            case (v.ctrl[9:7])
                3'd2: begin
                    r = a + b;
                    sr = $signed(r);
                    c = (r < a);
                    ov = (sa >= 0 && sb >= 0 && sr < 0) ||
                         (sa < 0 && sb < 0 && sr >= 0);
                end
                3'd3: begin
                    r = a - b;
                    sr = $signed(r);
                    c = (a >= b);
                    ov = (sa >= 0 && sb < 0 && sr < 0) ||
                         (sa < 0 && sb >= 0 && sr >= 0);
                end
                3'd4: r = a & b;
                3'd5: r = a | b;
                3'd6: r = a ^ b;
                default: r = b;
            endcase
        end
        f = {r[63], r == 64'd0, c, ov};
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".result"}, result_out, e_res);
        chk({tag, ".db"}, Db_out, e_db);
        chk({tag, ".rd"}, 64'(Rd_out), 64'(e_rd));
        chk({tag, ".mc"}, 64'(mem_ctrl_out), 64'(e_mc));
        chk({tag, ".valid"}, 64'(valid_out), 64'(e_v));
        chk({tag, ".flags"}, 64'(flags_out), 64'(e_fl));
    endtask

    // Drive one vector, advance one edge, compare every output.
    task automatic apply(input vec_t v, input string tag);
        logic [63:0] r;
        logic [3:0] f;
        Da_in = v.da; Db_in = v.db; control_in = v.ctrl; Rd_in = v.rd;
        Imm9_in = v.imm9; Imm12_in = v.imm12; shamt_in = v.shamt;
        valid_in = v.valid; stall = v.stall; flush = v.flush;
        model(v, r, f);
        #1;
        chk({tag, ".flags_comb"}, 64'(flags_out), 64'(e_fl));
        if (v.flush) begin
            e_res = r; e_db = v.db; e_rd = v.rd; e_mc = 3'b000; e_v = 1'b0;
        end else if (!v.stall) begin
            e_res = r; e_db = v.db; e_rd = v.rd; e_v = v.valid;
            e_mc = v.valid ? {v.ctrl[3], v.ctrl[2], v.ctrl[0]} : 3'b000;
            if (v.valid && v.ctrl[4]) e_fl = f;
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    function automatic vec_t mk(input logic [9:0] c, input logic [63:0] a,
                                input logic [63:0] b, input logic [8:0] i9,
                                input logic [11:0] i12, input logic [5:0] sh,
                                input logic vl);
        vec_t v;
        v.ctrl = c; v.da = a; v.db = b; v.rd = 5'(a[4:0] ^ 5'd7);
        v.imm9 = i9; v.imm12 = i12; v.shamt = sh; v.valid = vl;
        v.stall = 1'b0; v.flush = 1'b0;
        return v;
    endfunction

    task automatic clear_model;
        e_res = '0; e_db = '0; e_rd = '0; e_mc = '0; e_v = 1'b0; e_fl = '0;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'(int'($urandom_range(0, 15)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        vec_t v;
        logic [63:0] pre;
        tbl[0] = '{mk(10'b010_0_0_1_0_0_0_1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                      9'd0, 12'd0, 6'd0, 1'b1),
                   64'h8000_0000_0000_0000, 3'b001, 4'b1001};
        tbl[1] = '{mk(10'b011_0_0_1_0_0_0_1, 64'd5, 64'd5, 9'd0, 12'd0,
                      6'd0, 1'b1), 64'd0, 3'b001, 4'b0110};
        tbl[2] = '{mk(10'b010_1_0_0_0_1_0_1, 64'h100, 64'h55, 9'h1F8, 12'd0,
                      6'd0, 1'b1), 64'hF8, 3'b011, 4'b0110};
        tbl[3] = '{mk(10'b000_0_0_0_0_0_1_1, 64'hF0, 64'd9, 9'd0, 12'd0,
                      6'd4, 1'b1), 64'h0F, 3'b001, 4'b0110};
        tbl[4] = '{mk(10'b010_1_1_0_0_0_0_1, 64'd1, 64'd3, 9'd0, 12'hFFF,
                      6'd0, 1'b1), 64'h1000, 3'b001, 4'b0110};
        tbl[5] = '{mk(10'b010_1_0_0_1_0_0_0, 64'h200, 64'hABCD, 9'h010,
                      12'd0, 6'd0, 1'b1), 64'h210, 3'b100, 4'b0110};
        tbl[6] = '{mk(10'b100_0_0_1_0_0_0_1, 64'hF0F0, 64'h0F0F, 9'd0,
                      12'd0, 6'd0, 1'b1), 64'd0, 3'b001, 4'b0100};
        tbl[7] = '{mk(10'b011_0_0_1_0_0_0_1, 64'd3, 64'd5, 9'd0, 12'd0,
                      6'd0, 1'b1), 64'hFFFF_FFFF_FFFF_FFFE, 3'b001, 4'b1000};
        tbl[8] = '{mk(10'b000_0_0_1_0_0_1_1, 64'h8000_0000_0000_0001, 64'd0,
                      9'd0, 12'd0, 6'd0, 1'b1),
                   64'h8000_0000_0000_0001, 3'b001, 4'b1000};
        tbl[9] = '{mk(10'b010_0_0_1_0_0_0_1, 64'd1, 64'd2, 9'd0, 12'd0,
                      6'd0, 1'b0), 64'd3, 3'b000, 4'b1000};

        reset = 1'b1;
        Da_in = '0; Db_in = '0; control_in = '0; Rd_in = '0;
        Imm9_in = '0; Imm12_in = '0; shamt_in = '0;
        valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].v, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.const_res", i), result_out, tbl[i].eres);
            chk($sformatf("tbl%0d.const_mc", i), 64'(mem_ctrl_out),
                64'(tbl[i].emc));
            chk($sformatf("tbl%0d.const_fl", i), 64'(flags_out),
                64'(tbl[i].efl));
        end

        // Stall three cycles while offering a flag-setting instruction.
        apply(tbl[0].v, "pre_stall");
        v = tbl[1].v;
        v.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(v, $sformatf("stall%0d", i));
            chk($sformatf("stall%0d.frozen", i), result_out,
                64'h8000_0000_0000_0000);
        end
        // Flush with SetFlag: slot invalid, flags untouched.
        v.stall = 1'b0;
        v.flush = 1'b1;
        apply(v, "flush");
        chk("flush.flags_kept", 64'(flags_out), 64'h9);
        // Stall and flush together behave as flush.
        v = tbl[7].v;
        v.stall = 1'b1;
        v.flush = 1'b1;
        apply(v, "stall_flush");
        // Back-to-back flag setters.
        apply(tbl[6].v, "b2b0");
        apply(tbl[0].v, "b2b1");
        apply(tbl[1].v, "b2b2");

        // Asynchronous reset between edges.
        apply(tbl[0].v, "pre_reset");
        #2 reset = 1'b1;
        #1;
        clear_model();
        check_outs("async_reset");
        #2 reset = 1'b0;
        apply(tbl[2].v, "post_reset");

        // Reset asserted mid-stall discards the held slot.
        v = tbl[4].v;
        v.stall = 1'b1;
        apply(v, "mid_stall");
        #2 reset = 1'b1;
        #1;
        clear_model();
        check_outs("stall_reset");
        #2 reset = 1'b0;
        apply(v, "stall_after_reset");
        v.stall = 1'b0;
        apply(v, "capture_after_reset");

        for (int i = 0; i < 400; i++) begin
            v.ctrl = 10'($urandom_range(0, 1023));
            v.da = rnd64();
            v.db = rnd64();
            v.rd = 5'($urandom_range(0, 31));
            v.imm9 = 9'($urandom_range(0, 511));
            v.imm12 = 12'($urandom_range(0, 4095));
            v.shamt = 6'($urandom_range(0, 63));
            v.valid = ($urandom_range(0, 7) != 0);
            v.stall = ($urandom_range(0, 9) == 0);
            v.flush = ($urandom_range(0, 9) == 0);
            pre = e_res;
            apply(v, $sformatf("rnd%0d", i));
            if (pre === 64'hx) $display("note: undefined prior result");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
